// File: rtl/pp_interpolator_2.sv
// pp_interpolator_2: polyphase interpolate-by-2 FIR with a 1:1 bypass mode.
//   A filtered input produces two outputs (phase 0, then phase 1) from two
//   branches sharing one delay line. A bypass input produces one output,
//   Q-aligned to a unity coefficient. Latency is 1 cycle from accept to valid_out.
//   Backpressure: data_out/valid_out hold while !ready_out, and no input is
//   accepted meanwhile.
// Ports:
//   clk, arst_n        clock; asynchronous active-low reset
//   bypass             sampled at accept; 1 = pass-through, one output per input
//   coeffs             N_COEFFS signed prototype taps (static during operation)
//   data_in/valid_in/ready_in     input sample handshake
//   data_out/valid_out/ready_out  output sample handshake
module pp_interpolator_2 #(
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int N_COEFFS    = 8,
  localparam int N_PH             = N_COEFFS / 2,
  localparam int OUTPUT_WORD_SIZE = DATA_WIDTH + COEFF_WIDTH + $clog2(N_PH)
) (
  input  logic                                       clk,
  input  logic                                       arst_n,
  input  logic                                       bypass,
  input  logic [N_COEFFS-1:0][COEFF_WIDTH-1:0]       coeffs,
  input  logic signed [DATA_WIDTH-1:0]               data_in,
  input  logic                                       valid_in,
  output logic                                       ready_in,
  output logic signed [OUTPUT_WORD_SIZE-1:0]         data_out,
  output logic                                       valid_out,
  input  logic                                       ready_out
);

  localparam int OW = OUTPUT_WORD_SIZE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PH0  = 2'd1,
    ST_PH1  = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic signed [DATA_WIDTH-1:0] x_q [N_PH];
  logic signed [DATA_WIDTH-1:0] xs  [N_PH];   // delay line as it looks after a shift
  logic signed [OW-1:0]         hold_q, hold_d;
  logic signed [OW-1:0]         data_q, data_d;
  logic signed [OW-1:0]         y0, y1, byp_val;
  logic                         accept;
  logic                         load_filt, load_byp, move_hold;

  function automatic logic signed [OW-1:0] sext_c(input logic [COEFF_WIDTH-1:0] c);
    return {{(OW-COEFF_WIDTH){c[COEFF_WIDTH-1]}}, c};
  endfunction

  function automatic logic signed [OW-1:0] sext_x(input logic [DATA_WIDTH-1:0] x);
    return {{(OW-DATA_WIDTH){x[DATA_WIDTH-1]}}, x};
  endfunction

  // Handshake: ready_in depends only on state and ready_out, never valid_in.
  assign valid_out = (state_q != ST_IDLE);
  assign ready_in  = (state_q == ST_IDLE) || ((state_q == ST_PH1) && ready_out);
  assign accept    = valid_in && ready_in;
  assign data_out  = data_q;

  // Branch sums use the post-shift line so both phases reflect the new sample.
  always_comb begin
    xs[0] = data_in;
    for (int k = 1; k < N_PH; k++) begin
      xs[k] = x_q[k-1];
    end
    y0 = '0;
    y1 = '0;
    for (int k = 0; k < N_PH; k++) begin
      y0 = y0 + sext_c(coeffs[2*k])   * sext_x(xs[k]);
      y1 = y1 + sext_c(coeffs[2*k+1]) * sext_x(xs[k]);
    end
  end

  // Unity coefficient in Q(COEFF_WIDTH-1) means the bypass value is shifted up.
  assign byp_val = sext_x(data_in) <<< (COEFF_WIDTH - 1);

  always_comb begin
    state_d   = state_q;
    load_filt = 1'b0;
    load_byp  = 1'b0;
    move_hold = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bypass) begin
            load_byp = 1'b1;
            state_d  = ST_PH1;
          end else begin
            load_filt = 1'b1;
            state_d   = ST_PH0;
          end
        end
      end
      ST_PH0: begin
        if (ready_out) begin
          move_hold = 1'b1;
          state_d   = ST_PH1;
        end
      end
      ST_PH1: begin
        if (ready_out) begin
          // accept here implies a simultaneous transfer of the current output
          if (accept) begin
            if (bypass) begin
              load_byp = 1'b1;
              state_d  = ST_PH1;
            end else begin
              load_filt = 1'b1;
              state_d   = ST_PH0;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_d = data_q;
    hold_d = hold_q;
    if (load_filt) begin
      data_d = y0;
      hold_d = y1;
    end else if (load_byp) begin
      data_d = byp_val;
    end else if (move_hold) begin
      data_d = hold_q;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      hold_q  <= '0;
      for (int k = 0; k < N_PH; k++) begin
        x_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      hold_q  <= hold_d;
      // The line only moves on filtered accepts; bypass leaves it untouched.
      if (load_filt) begin
        for (int k = 0; k < N_PH; k++) begin
          x_q[k] <= xs[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_pp_interpolator_2.sv
module tb_pp_interpolator_2;

  logic                     clk;
  logic                     arst_n;
  logic                     bypass;
  logic [7:0][15:0]         coeffs;
  logic signed [15:0]       data_in;
  logic                     valid_in;
  logic                     ready_in;
  logic signed [33:0]       data_out;
  logic                     valid_out;
  logic                     ready_out;

  int errors = 0;
  int checks = 0;

  pp_interpolator_2 #(
    .DATA_WIDTH(16), .COEFF_WIDTH(16), .N_COEFFS(8)
  ) dut (
    .clk(clk), .arst_n(arst_n), .bypass(bypass), .coeffs(coeffs),
    .data_in(data_in), .valid_in(valid_in), .ready_in(ready_in),
    .data_out(data_out), .valid_out(valid_out), .ready_out(ready_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ramp_coeffs();
    for (int i = 0; i < 8; i++) coeffs[i] = 16'(i + 1);
  endtask

  // Impulse 1,0,0,0,0 with ready_out=1 starting from IDLE: expect 1..8,0,0.
  task automatic impulse_run(input string tag);
    ready_out = 1'b1;
    bypass    = 1'b0;
    data_in   = 16'sd1;
    valid_in  = 1'b1;
    step();
    data_in = 16'sd0;
    for (int i = 0; i < 10; i++) begin
      check({tag, "_dat"}, data_out, (i < 8) ? 64'(i + 1) : 64'sd0);
      check({tag, "_vld"}, 64'(valid_out), 64'd1);
      check({tag, "_rdy"}, 64'(ready_in), 64'(i % 2));
      if (i == 9) valid_in = 1'b0;
      step();
    end
    check({tag, "_idle_vld"}, 64'(valid_out), 64'd0);
    check({tag, "_idle_rdy"}, 64'(ready_in), 64'd1);
  endtask

  initial begin
    arst_n    = 1'b0;
    bypass    = 1'b0;
    data_in   = '0;
    valid_in  = 1'b0;
    ready_out = 1'b1;
    set_ramp_coeffs();
    #22;
    check("rst_dat", data_out, 64'sd0);
    check("rst_vld", 64'(valid_out), 64'd0);
    check("rst_rdy", 64'(ready_in), 64'd1);
    arst_n = 1'b1;
    step();
    check("post_rst_vld", 64'(valid_out), 64'd0);

    // Impulse response
    impulse_run("imp");

    // Backpressure in PH0
    data_in  = 16'sd1;
    valid_in = 1'b1;
    step();
    valid_in  = 1'b0;
    ready_out = 1'b0;
    check("bp_first", data_out, 64'sd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_dat", data_out, 64'sd1);
      check("bp_hold_vld", 64'(valid_out), 64'd1);
      check("bp_hold_rdy", 64'(ready_in), 64'd0);
    end
    ready_out = 1'b1;
    step();
    check("bp_rel_dat", data_out, 64'sd2);
    check("bp_rel_vld", 64'(valid_out), 64'd1);
    step();
    check("bp_end_vld", 64'(valid_out), 64'd0);

    // Reset mid-operation: line holds [1,0,0,0]; accept 5 -> y0 = 1*5 + 3*1 = 8
    data_in  = 16'sd5;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    check("mid_y0", data_out, 64'sd8);
    #2 arst_n = 1'b0;
    #1;
    check("arst_dat", data_out, 64'sd0);
    check("arst_vld", 64'(valid_out), 64'd0);
    check("arst_rdy", 64'(ready_in), 64'd1);
    #1 arst_n = 1'b1;
    step();
    impulse_run("imp2");

    // Full-scale throughput: all -32768, valid_in held high
    for (int i = 0; i < 8; i++) coeffs[i] = 16'h8000;
    data_in  = -16'sd32768;
    valid_in = 1'b1;
    step();
    for (int j = 0; j < 12; j++) begin
      // input number n = j/2+1; sum saturates the line after 4 inputs
      check("fs_dat", data_out,
            64'((j / 2 + 1 < 4) ? (j / 2 + 1) : 4) * 64'sd1073741824);
      check("fs_vld", 64'(valid_out), 64'd1);
      check("fs_rdy", 64'(ready_in), 64'(j % 2));
      if (j == 11) valid_in = 1'b0;
      step();
    end
    check("fs_end_vld", 64'(valid_out), 64'd0);

    // Bypass single and back-to-back
    bypass   = 1'b1;
    data_in  = -16'sd3;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    check("byp_m3", data_out, -64'sd98304);
    check("byp_m3_vld", 64'(valid_out), 64'd1);
    step();
    check("byp_idle_vld", 64'(valid_out), 64'd0);
    data_in  = 16'sd5;
    valid_in = 1'b1;
    step();
    check("byp_5", data_out, 64'sd163840);
    data_in = 16'sd6;
    step();
    check("byp_6", data_out, 64'sd196608);
    check("byp_6_rdy", 64'(ready_in), 64'd1);
    valid_in = 1'b0;
    step();
    check("byp_end_vld", 64'(valid_out), 64'd0);

    // Mode switch; line still [-32768 x4] if bypass left it alone.
    // accept 0 -> line [0,-32768,-32768,-32768]
    // y0 = -32768*(3+5+7) = -491520, y1 = -32768*(4+6+8) = -589824
    set_ramp_coeffs();
    bypass   = 1'b0;
    data_in  = 16'sd0;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    bypass   = 1'b1;
    check("ms_y0", data_out, -64'sd491520);
    step();
    check("ms_y1", data_out, -64'sd589824);
    check("ms_y1_vld", 64'(valid_out), 64'd1);
    data_in  = 16'sd2;
    valid_in = 1'b1;
    step();
    check("ms_byp", data_out, 64'sd65536);
    check("ms_byp_vld", 64'(valid_out), 64'd1);
    valid_in = 1'b0;
    bypass   = 1'b0;
    step();
    check("ms_end_vld", 64'(valid_out), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
